// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: descriptor layout,
// operation codes and FSM state encodings.
package layer_sequencer_pkg;

    localparam int DESC_W  = 34;

    localparam int OP_MSB  = 33;
    localparam int OP_LSB  = 32;
    localparam int KER_MSB = 31;
    localparam int KER_LSB = 27;
    localparam int STR_MSB = 26;
    localparam int STR_LSB = 24;
    localparam int IN_MSB  = 23;
    localparam int IN_LSB  = 12;
    localparam int OUT_MSB = 11;
    localparam int OUT_LSB = 0;

    localparam logic [1:0] OP_POOL = 2'b10;

    // Field order matches the descriptor bit layout, so a cast is enough.
    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [KER_MSB-KER_LSB:0] kernel;
        logic [STR_MSB-STR_LSB:0] stride;
        logic [IN_MSB-IN_LSB:0]   in_ch;
        logic [OUT_MSB-OUT_LSB:0] out_ch;
    } layer_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_LOADW  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/layer_sequencer_desc_fifo.sv
// Descriptor queue: synchronous FIFO with occupancy count and a flush
// that empties it in one cycle, taking priority over push and pop.
module seq_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Next pointers and count; power-of-2 depth lets pointers wrap freely.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: queues layer descriptors and runs each one through
// config, weight load, compute and output drain without host polling.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int DESC_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [DESC_W-1:0]             desc_data,
    input  logic                          abort,
    output logic [1:0]                    operation,
    output logic [4:0]                    kernel_size,
    output logic [2:0]                    stride,
    output logic [11:0]                   input_channel_size,
    output logic [11:0]                   output_channel_size,
    output logic                          weight_load_start,
    input  logic                          write_weight_finish,
    output logic                          run_start,
    input  logic                          layer_finish,
    output logic                          layer_done,
    output logic                          busy,
    output logic [$clog2(DESC_DEPTH):0]   queue_count,
    output logic [CNT_W-1:0]              layers_retired
);

    seq_state_e        state_q, state_d;
    layer_cfg_t        cfg_q, cfg_d;
    logic              wls_q, wls_d;
    logic              rs_q, rs_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  ret_q, ret_d;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [DESC_W-1:0] fifo_rdata;

    assign fifo_push = desc_valid && !fifo_full && !abort;

    seq_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .W     (DESC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (fifo_push),
        .wdata (desc_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    // Next-state logic; abort overrides every transition and any finish.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        wls_d    = 1'b0;
        rs_d     = 1'b0;
        done_d   = 1'b0;
        ret_d    = ret_q;
        fifo_pop = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cfg_d    = layer_cfg_t'(fifo_rdata);
                        state_d  = ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    if (cfg_q.op == OP_POOL) begin
                        state_d = ST_RUN;
                        rs_d    = 1'b1;
                    end else begin
                        state_d = ST_LOADW;
                        wls_d   = 1'b1;
                    end
                end
                ST_LOADW: begin
                    if (write_weight_finish) begin
                        state_d = ST_RUN;
                        rs_d    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (layer_finish) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ret_d   = ret_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, held config and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            wls_q   <= 1'b0;
            rs_q    <= 1'b0;
            done_q  <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            wls_q   <= wls_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
            ret_q   <= ret_d;
        end
    end

    assign desc_ready          = !fifo_full;
    assign operation           = cfg_q.op;
    assign kernel_size         = cfg_q.kernel;
    assign stride              = cfg_q.stride;
    assign input_channel_size  = cfg_q.in_ch;
    assign output_channel_size = cfg_q.out_ch;
    assign weight_load_start   = wls_q;
    assign run_start           = rs_q;
    assign layer_done          = done_q;
    assign busy                = (state_q != ST_IDLE);
    assign layers_retired      = ret_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: conv, pooling, full queue,
// stray events, abort and asynchronous reset mid-layer.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid;
    logic        desc_ready;
    logic [33:0] desc_data;
    logic        abort;
    logic [1:0]  operation;
    logic [4:0]  kernel_size;
    logic [2:0]  stride;
    logic [11:0] input_channel_size;
    logic [11:0] output_channel_size;
    logic        weight_load_start;
    logic        write_weight_finish;
    logic        run_start;
    logic        layer_finish;
    logic        layer_done;
    logic        busy;
    logic [2:0]  queue_count;
    logic [15:0] layers_retired;

    int checks   = 0;
    int failures = 0;
    int exp_ret  = 0;
    logic [33:0] dq [5];

    always #5 clk = ~clk;

    layer_sequencer #(.DESC_DEPTH(4), .CNT_W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .desc_valid          (desc_valid),
        .desc_ready          (desc_ready),
        .desc_data           (desc_data),
        .abort               (abort),
        .operation           (operation),
        .kernel_size         (kernel_size),
        .stride              (stride),
        .input_channel_size  (input_channel_size),
        .output_channel_size (output_channel_size),
        .weight_load_start   (weight_load_start),
        .write_weight_finish (write_weight_finish),
        .run_start           (run_start),
        .layer_finish        (layer_finish),
        .layer_done          (layer_done),
        .busy                (busy),
        .queue_count         (queue_count),
        .layers_retired      (layers_retired)
    );

    function automatic logic [33:0] mk(input logic [1:0] op, input logic [4:0] k,
                                       input logic [2:0] s, input logic [11:0] i,
                                       input logic [11:0] o);
        return {op, k, s, i, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] cfg_now();
        return {operation, kernel_size, stride, input_channel_size, output_channel_size};
    endfunction

    // Runs one queued layer from IDLE/queued to retired.
    task automatic do_layer(input logic [33:0] d, input string tag);
        int n = 0;
        while (!(weight_load_start || run_start) && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 64'(n < 10), 64'(1));
        check({tag, "_cfg"}, 64'(cfg_now()), 64'(d));
        if (d[33:32] != 2'b10) begin
            check({tag, "_wls"}, 64'(weight_load_start), 64'(1));
            write_weight_finish = 1'b1;
            tick();
            write_weight_finish = 1'b0;
        end else begin
            check({tag, "_no_wls"}, 64'(weight_load_start), 64'(0));
        end
        check({tag, "_run_start"}, 64'(run_start), 64'(1));
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        exp_ret++;
        check({tag, "_done"}, 64'(layer_done), 64'(1));
        check({tag, "_retired"}, 64'(layers_retired), 64'(exp_ret));
        tick();
        check({tag, "_done_clr"}, 64'(layer_done), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        desc_valid = 1'b0;
        desc_data = '0;
        abort = 1'b0;
        write_weight_finish = 1'b0;
        layer_finish = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(desc_ready), 64'(1));
        check("rst_count", 64'(queue_count), 64'(0));
        check("rst_cfg", 64'(cfg_now()), 64'(0));
        check("rst_pulses", 64'({weight_load_start, run_start, layer_done}), 64'(0));
        check("rst_retired", 64'(layers_retired), 64'(0));
        rst = 1'b0;
        tick();

        // Single conv layer with stray events in LOADW and RUN.
        desc_valid = 1'b1;
        desc_data = mk(2'b00, 5'd3, 3'd1, 12'd16, 12'd32);
        tick();
        desc_valid = 1'b0;
        check("c1_count", 64'(queue_count), 64'(1));
        tick();
        check("c1_busy", 64'(busy), 64'(1));
        check("c1_cfg", 64'(cfg_now()), 64'(mk(2'b00, 5'd3, 3'd1, 12'd16, 12'd32)));
        check("c1_wls_early", 64'(weight_load_start), 64'(0));
        tick();
        check("c1_wls", 64'(weight_load_start), 64'(1));
        tick();
        check("c1_wls_pulse", 64'(weight_load_start), 64'(0));
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        check("stray_lf", 64'({busy, run_start, layer_done}), 64'(3'b100));
        tick();
        tick();
        write_weight_finish = 1'b1;
        tick();
        write_weight_finish = 1'b0;
        check("c1_run_start", 64'(run_start), 64'(1));
        tick();
        check("c1_rs_pulse", 64'(run_start), 64'(0));
        write_weight_finish = 1'b1;
        tick();
        write_weight_finish = 1'b0;
        check("stray_wwf", 64'({busy, run_start, layer_done}), 64'(3'b100));
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        exp_ret++;
        check("c1_done", 64'(layer_done), 64'(1));
        check("c1_retired", 64'(layers_retired), 64'(exp_ret));
        tick();
        check("c1_idle", 64'({busy, layer_done}), 64'(0));
        check("c1_cfg_hold", 64'(cfg_now()), 64'(mk(2'b00, 5'd3, 3'd1, 12'd16, 12'd32)));

        // Pooling layer skips weight load.
        desc_valid = 1'b1;
        desc_data = mk(2'b10, 5'd2, 3'd2, 12'd8, 12'd8);
        tick();
        desc_valid = 1'b0;
        tick();
        check("pool_cfg_op", 64'(operation), 64'(2'b10));
        tick();
        check("pool_rs", 64'(run_start), 64'(1));
        check("pool_no_wls", 64'(weight_load_start), 64'(0));
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        exp_ret++;
        check("pool_done", 64'(layer_done), 64'(1));
        check("pool_retired", 64'(layers_retired), 64'(exp_ret));
        tick();

        // Back-to-back: first is popped, next four fill the queue.
        dq[0] = mk(2'b00, 5'd1, 3'd1, 12'd3, 12'd4);
        dq[1] = mk(2'b01, 5'd5, 3'd2, 12'd100, 12'd200);
        dq[2] = mk(2'b10, 5'd3, 3'd2, 12'd64, 12'd64);
        dq[3] = mk(2'b11, 5'd7, 3'd4, 12'hfff, 12'h001);
        dq[4] = mk(2'b00, 5'd31, 3'd7, 12'h800, 12'h7ff);
        for (int i = 0; i < 5; i++) begin
            desc_valid = 1'b1;
            desc_data = dq[i];
            tick();
        end
        check("full_count", 64'(queue_count), 64'(4));
        check("full_ready", 64'(desc_ready), 64'(0));
        desc_data = mk(2'b01, 5'd9, 3'd3, 12'd9, 12'd9);
        tick();
        desc_valid = 1'b0;
        check("full_reject", 64'(queue_count), 64'(4));
        check("b0_cfg", 64'(cfg_now()), 64'(dq[0]));
        write_weight_finish = 1'b1;
        tick();
        write_weight_finish = 1'b0;
        check("b0_rs", 64'(run_start), 64'(1));
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        exp_ret++;
        check("b0_done", 64'(layer_done), 64'(1));
        tick();
        do_layer(dq[1], "b1");
        do_layer(dq[2], "b2");
        do_layer(dq[3], "b3");
        do_layer(dq[4], "b4");
        tick();
        check("b_empty", 64'({busy, queue_count}), 64'(0));

        // Abort in RUN with two queued, finish and push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            desc_valid = 1'b1;
            desc_data = dq[i];
            tick();
        end
        desc_valid = 1'b0;
        check("ab_wls", 64'(weight_load_start), 64'(1));
        write_weight_finish = 1'b1;
        tick();
        write_weight_finish = 1'b0;
        check("ab_run", 64'({run_start, queue_count}), 64'({1'b1, 3'd2}));
        abort = 1'b1;
        layer_finish = 1'b1;
        desc_valid = 1'b1;
        desc_data = dq[3];
        tick();
        abort = 1'b0;
        layer_finish = 1'b0;
        desc_valid = 1'b0;
        check("ab_count", 64'(queue_count), 64'(0));
        check("ab_busy", 64'(busy), 64'(0));
        check("ab_no_done", 64'(layer_done), 64'(0));
        check("ab_retired", 64'(layers_retired), 64'(exp_ret));
        tick();
        check("ab_stay_idle", 64'({busy, layer_done}), 64'(0));

        // Async reset in the middle of LOADW, between clock edges.
        desc_valid = 1'b1;
        desc_data = dq[1];
        tick();
        desc_valid = 1'b0;
        tick();
        tick();
        check("ar_wls", 64'(weight_load_start), 64'(1));
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_busy", 64'(busy), 64'(0));
        check("ar_cfg", 64'(cfg_now()), 64'(0));
        check("ar_retired", 64'(layers_retired), 64'(0));
        check("ar_queue", 64'({desc_ready, queue_count}), 64'({1'b1, 3'd0}));
        tick();
        rst = 1'b0;
        exp_ret = 0;
        tick();
        desc_valid = 1'b1;
        desc_data = dq[4];
        tick();
        desc_valid = 1'b0;
        do_layer(dq[4], "ar_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
